// File: rtl/ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_mem_slave
// Description : AHB-Lite word-organised memory slave with byte/half/word access
//               and a two-cycle ERROR response. Define AHB_SLV_WAIT_EN to add
//               WAIT_CYCLES data-phase wait states to every good transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_mem_slave #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int          c_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] c_BYTES = 33'(MEM_WORDS) * 33'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [c_AW+1:0]   addr_q, addr_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       mem_q [MEM_WORDS];

    logic              w_accept;
    logic              w_err;
    logic [c_AW-1:0]   w_idx;
    logic [3:0]        w_be;
    logic              w_mem_we;
    logic              w_unused;

`ifdef AHB_SLV_WAIT_EN
    localparam int c_CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign w_accept = HSEL & HREADY & HTRANS[1];
    assign w_err    = (HSIZE > 3'd2)
                    | ((HSIZE == 3'd1) & HADDR[0])
                    | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                    | ({1'b0, HADDR} >= c_BYTES);
    assign w_idx    = addr_q[c_AW+1:2];
    assign w_unused = ^{HBURST, HPROT, (WAIT_CYCLES > 0)};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
`ifdef AHB_SLV_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_WAIT: begin
`ifdef AHB_SLV_WAIT_EN
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`else
                state_d = S_DATA;
`endif
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all finish this cycle, so a new address phase may be taken
                state_d = S_IDLE;
                if (w_accept) begin
                    addr_d  = HADDR[c_AW+1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE[1:0];
                    if (w_err) begin
                        state_d = S_ERR1;
`ifdef AHB_SLV_WAIT_EN
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = c_CNT_W'(WAIT_CYCLES - 1);
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

`ifdef AHB_SLV_WAIT_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        w_be = 4'b0000;
        case (size_q)
            2'd0:    w_be[addr_q[1:0]] = 1'b1;
            2'd1:    w_be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Reset wins over a completing write so an aborted transfer never lands
    assign w_mem_we = (state_q == S_DATA) && write_q && !HRESET;

    always_ff @(posedge HCLK) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem_q[w_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HREADYOUT = (state_q != S_WAIT) && (state_q != S_ERR1);
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign HRDATA    = ((state_q == S_DATA) && !write_q) ? mem_q[w_idx] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_mem_slave
// Description : Randomised pipelined AHB-Lite bench for ahb_lite_mem_slave,
//               checked against a byte-addressed reference memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_mem_slave;

    localparam int MEM_WORDS   = 256;
    localparam int WAIT_CYCLES = 2;
`ifdef AHB_SLV_WAIT_EN
    localparam int c_EXP_WAIT  = WAIT_CYCLES;
`else
    localparam int c_EXP_WAIT  = 0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahb_lite_mem_slave #(
        .MEM_WORDS   (MEM_WORDS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    int          n_cmp = 0;
    int          n_err = 0;
    byte unsigned ref_mem [MEM_WORDS*4];
    xfer_t       stim_q[$];
    xfer_t       ap;
    xfer_t       dp;
    logic        dp_v;
    logic        dp_err;
    int          dp_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                                 input logic wr, input logic [2:0] size, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.addr = addr; x.wr = wr; x.size = size; x.wdata = wdata;
        return x;
    endfunction

    // Reference model: a flat little-endian byte memory
    function automatic bit ref_is_err(input xfer_t x);
        if (x.size > 3'd2) return 1'b1;
        if (x.size == 3'd1 && x.addr[0]) return 1'b1;
        if (x.size == 3'd2 && x.addr[1:0] != 2'b00) return 1'b1;
        if (x.addr >= 32'(MEM_WORDS*4)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void ref_write(input xfer_t x);
        int n = 1 << x.size;
        for (int k = 0; k < n; k++) begin
            int a = int'(x.addr) + k;
            ref_mem[a] = x.wdata[8*(a%4) +: 8];
        end
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        int b = int'(addr) & ~3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int    r = $urandom_range(0, 99);
        x.sel   = 1'b1;
        x.trans = 2'b10 | 2'($urandom_range(0, 1));
        x.wr    = 1'($urandom_range(0, 1));
        x.wdata = $urandom();
        x.size  = 3'($urandom_range(0, 2));
        x.addr  = (r % 2 == 0) ? $urandom_range(0, 63) : $urandom_range(0, MEM_WORDS*4-1);
        if (r < 8) begin
            x.trans = 2'($urandom_range(0, 1));
        end else if (r < 14) begin
            x.sel = 1'b0;
        end else if (r < 20) begin
            x.size = 3'($urandom_range(3, 7));
        end else if (r < 25) begin
            x.addr = 32'(MEM_WORDS*4) + $urandom_range(0, 4096);
        end else if (r >= 32) begin
            if (x.size == 3'd1) x.addr[0] = 1'b0;
            else if (x.size == 3'd2) x.addr[1:0] = 2'b00;
        end
        return x;
    endfunction

    function automatic xfer_t next_xfer();
        if (stim_q.size() > 0) return stim_q.pop_front();
        return rand_xfer();
    endfunction

    task automatic drive_bus();
        HSEL   = ap.sel;
        HTRANS = ap.trans;
        HADDR  = ap.addr;
        HWRITE = ap.wr;
        HSIZE  = ap.size;
        HBURST = 3'($urandom());
        HPROT  = 4'($urandom());
        HWDATA = (dp_v && dp.wr) ? dp.wdata : $urandom();
    endtask

    // One bus cycle: check the current data phase, then advance the pipeline
    task automatic step();
        logic        rdy;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_data;
        @(negedge HCLK);
        e_rdy  = 1'b1;
        e_resp = 1'b0;
        e_data = 32'h0;
        if (dp_v) begin
            if (dp_err) begin
                e_resp = 1'b1;
                e_rdy  = (dp_cyc >= 1);
            end else begin
                e_rdy = (dp_cyc >= c_EXP_WAIT);
                if (e_rdy && !dp.wr) e_data = ref_read(dp.addr);
            end
        end
        check_eq("HREADYOUT", {31'b0, HREADYOUT}, {31'b0, e_rdy});
        check_eq("HRESP", {31'b0, HRESP}, {31'b0, e_resp});
        check_eq("HRDATA", HRDATA, e_data);
        rdy = HREADYOUT;
        if (dp_v && dp_cyc > c_EXP_WAIT + 2) begin
            check_eq("data_phase_timeout", 32'(dp_cyc), 32'(c_EXP_WAIT + 1));
            dp_v = 1'b0;
        end
        @(posedge HCLK);
        if (rdy) begin
            if (dp_v && !dp_err && dp.wr) ref_write(dp);
            if (ap.sel && ap.trans[1]) begin
                dp     = ap;
                dp_v   = 1'b1;
                dp_err = ref_is_err(ap);
                dp_cyc = 0;
            end else begin
                dp_v = 1'b0;
            end
            ap = next_xfer();
        end else begin
            dp_cyc++;
        end
        #1;
        drive_bus();
    endtask

    logic [31:0] old_word;

    initial begin
        dp_v   = 1'b0;
        dp_err = 1'b0;
        dp_cyc = 0;
        ap     = mk(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
        dp     = ap;
        HRESET = 1'b1;
        drive_bus();
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check_eq("reset_HREADYOUT", {31'b0, HREADYOUT}, 32'd1);
        check_eq("reset_HRESP", {31'b0, HRESP}, 32'd0);
        check_eq("reset_HRDATA", HRDATA, 32'h0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Preload every word so all later reads have a known model value
        for (int w = 0; w < MEM_WORDS; w++)
            stim_q.push_back(mk(1'b1, 2'b10, 32'(w*4), 1'b1, 3'd2, $urandom()));
        stim_q.push_back(mk(1'b1, 2'b10, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF));
        stim_q.push_back(mk(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'h0));
        stim_q.push_back(mk(1'b1, 2'b10, 32'h10, 1'b1, 3'd2, 32'h11223344));
        stim_q.push_back(mk(1'b1, 2'b10, 32'h13, 1'b1, 3'd0, 32'hAA000000));
        stim_q.push_back(mk(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'h0));
        stim_q.push_back(mk(1'b1, 2'b10, 32'h02, 1'b0, 3'd2, 32'h0));
        stim_q.push_back(mk(1'b1, 2'b10, 32'h00, 1'b0, 3'd2, 32'h0));
        stim_q.push_back(mk(1'b1, 2'b10, 32'h02, 1'b1, 3'd2, 32'h55555555));
        stim_q.push_back(mk(1'b1, 2'b10, 32'h00, 1'b0, 3'd2, 32'h0));
        stim_q.push_back(mk(1'b1, 2'b10, 32'h400, 1'b1, 3'd2, 32'h12345678));
        stim_q.push_back(mk(1'b1, 2'b10, 32'h00, 1'b0, 3'd2, 32'h0));
        stim_q.push_back(mk(1'b1, 2'b10, 32'h20, 1'b1, 3'd2, 32'h5));
        stim_q.push_back(mk(1'b1, 2'b10, 32'h20, 1'b0, 3'd2, 32'h0));
        while (stim_q.size() > 0) step();
        repeat (2000) step();

        // Drain the pipeline with idle cycles
        for (int i = 0; i < 4; i++) stim_q.push_back(mk(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0));
        while (stim_q.size() > 0) step();
        repeat (6) step();

        // Reset while a write is in its data phase: no write may land
        old_word = ref_read(32'h40);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h40; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = ~old_word; HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check_eq("abort_HREADYOUT", {31'b0, HREADYOUT}, 32'd1);
        check_eq("abort_HRESP", {31'b0, HRESP}, 32'd0);
        check_eq("abort_HRDATA", HRDATA, 32'h0);
        @(posedge HCLK);
        #1;
        dp_v = 1'b0;
        ap   = mk(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
        drive_bus();
        stim_q.push_back(mk(1'b1, 2'b10, 32'h40, 1'b0, 3'd2, 32'h0));
        for (int i = 0; i < 3; i++) stim_q.push_back(mk(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0));
        while (stim_q.size() > 0) step();
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
